// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: steers store data onto byte lanes and extracts/extends load data.
// It drives a single-outstanding req/ack memory port, with a watchdog that raises a bus error when ack never comes.
module rv32i_lsu #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_is_store,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_store_data,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [3:0]       o_mem_wstrb,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic             i_mem_ack,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic             o_resp_valid,
    output logic [WIDTH-1:0] o_load_data,
    output logic [1:0]       o_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic               w_illegal;
    logic               w_misal;
    logic               w_expire;

    logic               r_is_store;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;
    logic [WIDTH-1:0]   r_addr;
    logic [3:0]         r_wstrb;
    logic [WIDTH-1:0]   r_wdata;
    logic [WIDTH-1:0]   r_load_data;
    logic [1:0]         r_err;

    function automatic logic [31:0] steer_data(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   steer_data = {4{sd[7:0]}};
            2'b01:   steer_data = {2{sd[15:0]}};
            default: steer_data = sd;
        endcase
    endfunction

    function automatic logic [3:0] steer_strb(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   steer_strb = 4'b0001 << lo;
            2'b01:   steer_strb = 4'b0011 << lo;
            default: steer_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rd[{lo, 3'b000} +: 8];
        h = rd[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extract = 32'(b);
            3'b001:  extract = 32'(h);
            3'b100:  extract = {24'd0, b};
            3'b101:  extract = {16'd0, h};
            default: extract = rd;
        endcase
    endfunction

    // Illegal encodings outrank misalignment; byte accesses are never misaligned.
    assign w_illegal = i_is_store ? (i_funct3 != 3'b000 && i_funct3 != 3'b001 && i_funct3 != 3'b010)
                                  : (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111);
    assign w_misal   = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                       (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
    assign w_expire  = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_illegal || w_misal) ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (i_mem_ack || w_expire) w_state_nxt = S_DONE;
                else                       w_cnt_nxt   = r_cnt + 1'b1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers carry no reset; every output is gated by state instead.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_is_store  <= i_is_store;
            r_funct3    <= i_funct3;
            r_addr_lo   <= i_addr[1:0];
            r_addr      <= {i_addr[WIDTH-1:2], 2'b00};
            r_wdata     <= steer_data(i_funct3, i_store_data);
            r_wstrb     <= i_is_store ? steer_strb(i_funct3, i_addr[1:0]) : 4'b0000;
            r_err       <= w_illegal ? 2'b11 : (w_misal ? 2'b01 : 2'b00);
            r_load_data <= '0;
        end else if (r_state == S_ACCESS) begin
            if (i_mem_ack) begin
                r_err       <= 2'b00;
                r_load_data <= r_is_store ? '0 : extract(r_funct3, r_addr_lo, i_mem_rdata);
            end else if (w_expire) begin
                r_err       <= 2'b10;
                r_load_data <= '0;
            end
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_mem_req    = (r_state == S_ACCESS);
    assign o_mem_we     = o_mem_req & r_is_store;
    assign o_mem_addr   = o_mem_req ? r_addr  : '0;
    assign o_mem_wstrb  = o_mem_req ? r_wstrb : 4'b0000;
    assign o_mem_wdata  = o_mem_req ? r_wdata : '0;
    assign o_resp_valid = (r_state == S_DONE);
    assign o_load_data  = o_resp_valid ? r_load_data : '0;
    assign o_err        = o_resp_valid ? r_err : 2'b00;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed table-driven bench for rv32i_lsu plus hand-written reset-during-access sequence.
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] load_data;
    logic [1:0]  err;

    int tests = 0;
    int fails = 0;

    rv32i_lsu #(.WIDTH(32), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata), .o_resp_valid(resp_valid), .o_load_data(load_data),
        .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          ack_at;
        logic [1:0]  e_err;
        logic [31:0] e_load;
        int          e_acc;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int acc;
        int lat;
        bit got;
        acc = 0;
        lat = 0;
        got = 0;
        @(posedge clk); #1;
        check($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
        is_store   = v.st;
        funct3     = v.f3;
        addr       = v.a;
        store_data = v.sd;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            lat++;
            mem_ack = 1'b0;
            if (resp_valid) begin
                got = 1;
                check($sformatf("v%0d err", idx), 32'(err), 32'(v.e_err));
                check($sformatf("v%0d load_data", idx), load_data, v.e_load);
                check($sformatf("v%0d access_cycles", idx), acc, v.e_acc);
                check($sformatf("v%0d latency", idx), lat, v.e_acc + 1);
            end else if (mem_req) begin
                acc++;
                check($sformatf("v%0d mem_addr", idx), mem_addr, v.a & 32'hFFFF_FFFC);
                check($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.st));
                check($sformatf("v%0d mem_wstrb", idx), 32'(mem_wstrb), 32'(v.e_strb));
                if (v.st) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
                if (acc == v.ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rd;
                end
                @(posedge clk); #1;
            end else begin
                tests++;
                fails++;
                $display("FAIL v%0d neither mem_req nor resp_valid at cycle %0d", idx, lat);
                @(posedge clk); #1;
            end
        end
        mem_ack = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL v%0d no response within bound", idx);
        end
        @(posedge clk); #1;
        check($sformatf("v%0d resp_pulse_end", idx), 32'(resp_valid), 32'd0);
        check($sformatf("v%0d err_cleared", idx), 32'(err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;

        //          st   f3      addr          sdata         rdata        ack err    load          acc strb     wdata
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 3,  2'b00, 32'hDEADBEEF, 3,  4'b0000, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF1234, 1,  2'b00, 32'hFFFFFF80, 1,  4'b0000, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF1234, 1,  2'b00, 32'h00000080, 1,  4'b0000, 32'h0};
        vecs[3]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF1234, 2,  2'b00, 32'h000080FF, 2,  4'b0000, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF1234, 1,  2'b00, 32'hFFFF80FF, 1,  4'b0000, 32'h0};
        vecs[5]  = '{1'b1, 3'b000, 32'h0000_0202, 32'h000000A5, 32'h0,        1,  2'b00, 32'h0,        1,  4'b0100, 32'hA5A5A5A5};
        vecs[6]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h1234BEEF, 32'h0,        1,  2'b00, 32'h0,        1,  4'b1100, 32'hBEEFBEEF};
        vecs[7]  = '{1'b1, 3'b010, 32'h0000_0204, 32'h11223344, 32'h0,        2,  2'b00, 32'h0,        2,  4'b1111, 32'h11223344};
        vecs[8]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0,  2'b01, 32'h0,        0,  4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 3'b011, 32'h0000_0101, 32'h0,        32'h0,        0,  2'b11, 32'h0,        0,  4'b0000, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0,  2'b01, 32'h0,        0,  4'b0000, 32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h0000_0200, 32'h0,        32'h0,        0,  2'b11, 32'h0,        0,  4'b0000, 32'h0};
        vecs[12] = '{1'b1, 3'b010, 32'h0000_0202, 32'h0,        32'h0,        0,  2'b01, 32'h0,        0,  4'b0000, 32'h0};
        vecs[13] = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h00007F00, 2,  2'b00, 32'h0000007F, 2,  4'b0000, 32'h0};
        vecs[14] = '{1'b0, 3'b010, 32'h0000_0110, 32'h0,        32'h12345678, 0,  2'b10, 32'h0,        16, 4'b0000, 32'h0};
        vecs[15] = '{1'b0, 3'b010, 32'h0000_0110, 32'h0,        32'hCAFEF00D, 16, 2'b00, 32'hCAFEF00D, 16, 4'b0000, 32'h0};
        vecs[16] = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h12348001, 1,  2'b00, 32'hFFFF8001, 1,  4'b0000, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst load_data", load_data, 32'd0);
        check("rst err", 32'(err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an access: request must vanish with no response, late ack ignored.
        @(posedge clk); #1;
        is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midrst mem_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst mem_req", 32'(mem_req), 32'd0);
        check("midrst req_ready", 32'(req_ready), 32'd1);
        check("midrst resp_valid", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("late_ack resp_valid c%0d", k), 32'(resp_valid), 32'd0);
            check($sformatf("late_ack mem_req c%0d", k), 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
        run_vec(17, '{1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0BADF00D, 1, 2'b00, 32'h0BADF00D, 1, 4'b0000, 32'h0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
